ni_hl_hdr_enc: RTL and testbench
================================

Name: ni_hl_hdr_enc

Overview:
- Source-side network-interface injector for the hierarchical-leader NoC.
- Accepts packet requests from the local core: destination bitmap, body length, body payloads.
- Classifies each request as unicast or multicast and computes um_type, uni_dst, mult_dst (DOC), src_pos and src_dst, which are the header fields the router decoder consumes.
- Serialises HEAD/BODY/TAIL flits into the local router input port under credit-based flow control.

Parameters:
MY_XPOS, 0, source node X coordinate
MY_YPOS, 0, source node Y coordinate
BUF_DEPTH, 4, local router input-buffer depth in flits; initial credit count
LENW, 4, width of body-length field
DATAW, 32, payload width per flit

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  packet request valid
req_ready  output  1  request accepted when req_valid&&req_ready
req_dst  input  `MADDR+1  destination bitmap, bit index = x*`ROW+y
req_len  input  LENW  number of body flits after head; 0 = single-flit packet
dat_valid  input  1  payload word valid
dat_ready  output  1  payload word consumed
dat_data  input  DATAW  payload word
credit_in  input  1  one-cycle pulse, router freed one buffer slot
flit_valid  output  1  flit presented to router this cycle
flit_type  output  2  0 HEAD, 1 BODY, 2 TAIL, 3 HEADTAIL
flit_um_type  output  1  0 unicast, 1 multicast
flit_uni_dst  output  `NODEW+1  unicast destination node id
flit_mult_dst  output  `MADDR+1  multicast DOC bitmap
flit_src_pos  output  2  source quadrant
flit_src_dst  output  `MSRC_BW+1  destination count
flit_data  output  DATAW  payload; 0 on HEAD
drop_err  output  1  one-cycle pulse, request discarded

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). Reset forces state IDLE, credit count = BUF_DEPTH, all flit_* outputs = 0, flit_valid = 0, drop_err = 0, req_ready = 0, dat_ready = 0.
- Reset mid-packet abandons the packet. No partial tail is sent. Credits return to BUF_DEPTH.
- Header computation on acceptance:
  - Clear the MY_POS bit of req_dst, where MY_POS = MY_XPOS*`ROW+MY_YPOS. This is the masked bitmap.
  - popcount = number of set bits in the masked bitmap.
  - If popcount = 0: drop the request and pulse drop_err the next cycle. Stay IDLE. No flit is sent.
  - If popcount = 1: um_type = 0, uni_dst = index of the set bit, mult_dst = 0.
  - If popcount > 1: um_type = 1, mult_dst = masked bitmap, uni_dst = 0.
  - src_pos = {MY_XPOS >= `COL/2, MY_YPOS >= `ROW/2}.
  - src_dst = popcount, saturated to all-ones at `MSRC_BW+1 bits.
  - Header fields are registered at acceptance and stay stable until the packet's last flit is sent.
- States:
  - IDLE: req_ready = 1. On accept: go to HEAD, or stay IDLE if dropped. The remaining body count is loaded from req_len.
  - HEAD: flit_valid = 1 when credit > 0. flit_type = HEADTAIL if len = 0, else HEAD. Once sent: go to IDLE if len = 0, else BODY.
  - BODY: dat_ready = credit>0. flit_valid = dat_valid && credit>0. flit_data = dat_data. flit_type = TAIL when remaining = 1, else BODY. Each send decrements remaining. Sending the TAIL returns to IDLE.
- A flit is sent in any cycle where flit_valid = 1; the router always accepts a flit when credit > 0. flit_* outputs are combinational from state and registers. No flit_valid is asserted when credit = 0.
- Credit counter update:
  - Send without credit_in: decrement.
  - credit_in without send: increment.
  - Both in the same cycle: unchanged.
  - credit_in at count BUF_DEPTH is a protocol error: the count saturates and a simulation assertion fires.
- Throughput: one flit per cycle when credits and payload are available. Latency from request acceptance to HEAD flit_valid is 1 cycle. There is no back-to-back packet overlap: the next req_ready comes in the cycle after TAIL.
- dat_valid outside BODY is ignored and dat_ready stays 0.

Test Plan:
- Reset with MY_XPOS=1, MY_YPOS=2, `ROW=4 -> all outputs 0. After release, req_ready=1 and credit count=BUF_DEPTH=4.
- req_dst has only bit 9 set, req_len=2, payloads 0xA, 0xB -> HEAD with um_type=0, uni_dst=9, src_dst=1; then BODY 0xA, then TAIL 0xB on consecutive cycles.
- req_dst=0x0000_0441 (bits 0, 6, 10), req_len=0, MY_POS=6 -> single HEADTAIL flit with um_type=1, mult_dst=0x401, src_dst=2.
- req_dst=only the MY_POS bit -> no flit_valid; drop_err pulses one cycle; req_ready stays 1.
- BUF_DEPTH=4, req_len=7, no credit_in -> exactly 4 flits sent, then stall. One credit_in pulse -> exactly one more flit.
- credit_in coincident with a send, and reset asserted during BODY -> the credit count is unchanged for the coincident cycle; the reset returns to IDLE with credit=4 and no TAIL emitted.

Source files
------------

// File: rtl/ni_hl_hdr_enc.sv
// ni_hl_hdr_enc: source NI injector computing hierarchical-leader headers and
// serialising HEAD/BODY/TAIL flits into the local router under credit flow control.
//   req_*    packet request from the core (destination bitmap, body length)
//   dat_*    body payload stream from the core
//   credit_in one-cycle pulse per router buffer slot freed
//   flit_*   flit presented to the local router input port
//   drop_err pulse when a request has no destination other than this node
`ifndef ROW
`define ROW 4
`endif
`ifndef COL
`define COL 4
`endif
`ifndef MADDR
`define MADDR 15
`endif
`ifndef NODEW
`define NODEW 3
`endif
`ifndef MSRC_BW
`define MSRC_BW 1
`endif
module ni_hl_hdr_enc #(
    parameter int MY_XPOS   = 0,
    parameter int MY_YPOS   = 0,
    parameter int BUF_DEPTH = 4,
    parameter int LENW      = 4,
    parameter int DATAW     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [`MADDR:0]   req_dst,
    input  logic [LENW-1:0]   req_len,
    input  logic              dat_valid,
    output logic              dat_ready,
    input  logic [DATAW-1:0]  dat_data,
    input  logic              credit_in,
    output logic              flit_valid,
    output logic [1:0]        flit_type,
    output logic              flit_um_type,
    output logic [`NODEW:0]   flit_uni_dst,
    output logic [`MADDR:0]   flit_mult_dst,
    output logic [1:0]        flit_src_pos,
    output logic [`MSRC_BW:0] flit_src_dst,
    output logic [DATAW-1:0]  flit_data,
    output logic              drop_err
);
    localparam int NB = `MADDR + 1;
    localparam int MY_POS = MY_XPOS * `ROW + MY_YPOS;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(NB + 1);
    localparam int SW = `MSRC_BW + 1;
    localparam logic [1:0] SRC_POS = {MY_XPOS >= `COL / 2, MY_YPOS >= `ROW / 2};

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t          state;
    logic [CW-1:0]   credit;
    logic [LENW-1:0] rem;
    logic            um_q;
    logic [`NODEW:0] uni_q;
    logic [`MADDR:0] mult_q;
    logic [SW-1:0]   sdst_q;
    logic [`MADDR:0] masked;
    logic [PW-1:0]   pc;
    logic [`NODEW:0] idx;
    logic            active, cred_ok, accept;

    // Destination bitmap with this node removed; popcount and highest set index.
    always_comb begin
        masked = req_dst;
        masked[MY_POS] = 1'b0;
        pc = '0;
        idx = '0;
        for (int i = 0; i < NB; i++) begin
            if (masked[i]) begin
                pc = pc + PW'(1);
                idx = i[`NODEW:0];
            end
        end
    end

    assign active        = state != IDLE;
    assign cred_ok       = credit != '0;
    // Ready is held low while reset is asserted, not just after it.
    assign req_ready     = rst_n && state == IDLE;
    assign accept        = req_valid && req_ready;
    assign dat_ready     = state == BODY && cred_ok;
    assign flit_valid    = cred_ok && (state == HEAD || (state == BODY && dat_valid));
    assign flit_type     = state == HEAD ? (rem == '0 ? 2'd3 : 2'd0) :
                           state == BODY ? (rem == LENW'(1) ? 2'd2 : 2'd1) : 2'd0;
    assign flit_um_type  = active && um_q;
    assign flit_uni_dst  = active ? uni_q : '0;
    assign flit_mult_dst = active ? mult_q : '0;
    assign flit_src_pos  = active ? SRC_POS : 2'b00;
    assign flit_src_dst  = active ? sdst_q : '0;
    assign flit_data     = state == BODY ? dat_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            credit   <= CW'(BUF_DEPTH);
            rem      <= '0;
            um_q     <= 1'b0;
            uni_q    <= '0;
            mult_q   <= '0;
            sdst_q   <= '0;
            drop_err <= 1'b0;
        end else begin
            drop_err <= accept && pc == '0;
            if (flit_valid && !credit_in)
                credit <= credit - CW'(1);
            else if (credit_in && !flit_valid && credit != CW'(BUF_DEPTH))
                credit <= credit + CW'(1);
            case (state)
                IDLE: if (accept && pc != '0) begin
                    state  <= HEAD;
                    rem    <= req_len;
                    um_q   <= pc > PW'(1);
                    uni_q  <= pc == PW'(1) ? idx : '0;
                    mult_q <= pc > PW'(1) ? masked : '0;
                    sdst_q <= pc > PW'(2 ** SW - 1) ? '1 : SW'(pc);
                end
                HEAD: if (flit_valid) state <= rem == '0 ? IDLE : BODY;
                BODY: if (flit_valid) begin
                    rem <= rem - LENW'(1);
                    if (rem == LENW'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(credit_in && !flit_valid && credit == CW'(BUF_DEPTH)))
        else $error("credit_in received with all credits already held");
endmodule

// File: tb/tb_ni_hl_hdr_enc.sv
// tb_ni_hl_hdr_enc: directed bench with a flit-stream scoreboard for ni_hl_hdr_enc.
`ifndef ROW
`define ROW 4
`endif
`ifndef COL
`define COL 4
`endif
`ifndef MADDR
`define MADDR 15
`endif
`ifndef NODEW
`define NODEW 3
`endif
`ifndef MSRC_BW
`define MSRC_BW 1
`endif
module tb_ni_hl_hdr_enc;
    logic        clk = 0, rst_n = 0, req_valid = 0, dat_valid = 0, credit_in = 0;
    logic [15:0] req_dst = '0;
    logic [3:0]  req_len = '0;
    logic [31:0] dat_data = '0;
    logic        req_ready, dat_ready, flit_valid, flit_um_type, drop_err;
    logic [1:0]  flit_type, flit_src_pos, flit_src_dst;
    logic [3:0]  flit_uni_dst;
    logic [15:0] flit_mult_dst;
    logic [31:0] flit_data;

    ni_hl_hdr_enc #(.MY_XPOS(1), .MY_YPOS(2), .BUF_DEPTH(4), .LENW(4), .DATAW(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_dst(req_dst), .req_len(req_len), .dat_valid(dat_valid), .dat_ready(dat_ready),
        .dat_data(dat_data), .credit_in(credit_in), .flit_valid(flit_valid),
        .flit_type(flit_type), .flit_um_type(flit_um_type), .flit_uni_dst(flit_uni_dst),
        .flit_mult_dst(flit_mult_dst), .flit_src_pos(flit_src_pos),
        .flit_src_dst(flit_src_dst), .flit_data(flit_data), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, mcred = 4, sent = 0, drops = 0, s0 = 0, d0 = 0;
    logic [58:0] expq[$];
    logic [31:0] pq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected flits of one request, derived from the routing rules (node 6 is this node).
    function automatic void push_pkt(input logic [15:0] dst, input int len, input logic [31:0] base);
        logic [15:0] m = dst & ~16'h0040;
        int pc = $countones(m);
        int idx = 0;
        logic [6:0] hdr;
        logic [15:0] mult;
        if (pc == 0) return;
        for (int i = 0; i < 16; i++) if (m[i]) idx = i;
        hdr  = {pc > 1, pc == 1 ? 4'(idx) : 4'd0, 2'b01};
        mult = pc > 1 ? m : 16'd0;
        expq.push_back({len == 0 ? 2'd3 : 2'd0, hdr[6:2], mult, hdr[1:0], pc > 3 ? 2'd3 : 2'(pc), 32'd0});
        for (int i = 1; i <= len; i++) begin
            pq.push_back(base + 32'(i - 1));
            expq.push_back({i == len ? 2'd2 : 2'd1, hdr[6:2], mult, hdr[1:0], pc > 3 ? 2'd3 : 2'(pc), base + 32'(i - 1)});
        end
    endfunction

    // Payload source: presents the head of pq, pops it once the DUT consumes it.
    initial begin
        logic cons;
        forever begin
            @(negedge clk);
            cons = rst_n && dat_valid && dat_ready;
            @(posedge clk);
            #1;
            if (cons && pq.size() > 0) void'(pq.pop_front());
            dat_valid = pq.size() > 0;
            dat_data  = pq.size() > 0 ? pq[0] : 32'd0;
        end
    end

    // Scoreboard and credit model, evaluated mid-cycle.
    initial begin
        logic [58:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) mcred = 4;
            else begin
                if (flit_valid) begin
                    sent++;
                    chk("flit_has_credit", 64'(mcred > 0), 64'd1);
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_flit: type %0d data %0h with none expected", flit_type, flit_data);
                    end else begin
                        e = expq.pop_front();
                        chk("flit", {flit_type, flit_um_type, flit_uni_dst, flit_mult_dst,
                                     flit_src_pos, flit_src_dst, flit_data}, e);
                    end
                end
                if (drop_err) drops++;
                if (credit_in && !flit_valid) mcred++;
                else if (flit_valid && !credit_in) mcred--;
            end
        end
    end

    task automatic send_req(input logic [15:0] dst, input logic [3:0] len);
        int n = 0;
        @(posedge clk);
        #1;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout: ready %0b required 1", req_ready);
        end
        req_valid = 1;
        req_dst   = dst;
        req_len   = len;
        @(posedge clk);
        #1;
        req_valid = 0;
    endtask

    // Return credits until the router buffer is empty and every expected flit has gone out.
    task automatic refill();
        int n = 0;
        while ((mcred < 4 || expq.size() > 0) && n < 300) begin
            @(posedge clk);
            #1;
            credit_in = mcred < 4;
            n++;
        end
        credit_in = 0;
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d flits outstanding, credits %0d required 4", expq.size(), mcred);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flit_valid", 64'(flit_valid), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_dat_ready", 64'(dat_ready), 0);
        chk("rst_drop_err", 64'(drop_err), 0);
        chk("rst_fields", {flit_type, flit_um_type, flit_uni_dst, flit_mult_dst, flit_src_pos, flit_src_dst, flit_data}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 1);

        push_pkt(16'h0200, 2, 32'hA);
        send_req(16'h0200, 2);
        @(negedge clk);
        chk("t1_head", {flit_valid, flit_type, flit_um_type, flit_uni_dst, flit_src_dst}, {1'b1, 2'd0, 1'b0, 4'd9, 2'd1});
        @(negedge clk);
        chk("t1_body", {flit_valid, flit_type, flit_data}, {1'b1, 2'd1, 32'hA});
        @(negedge clk);
        chk("t1_tail", {flit_valid, flit_type, flit_data}, {1'b1, 2'd2, 32'hB});
        @(negedge clk);
        chk("t1_ready_after_tail", 64'(req_ready), 1);
        refill();

        push_pkt(16'h0441, 0, 0);
        send_req(16'h0441, 0);
        @(negedge clk);
        chk("t2_headtail", {flit_valid, flit_type, flit_um_type, flit_uni_dst, flit_mult_dst, flit_src_pos, flit_src_dst, flit_data},
                           {1'b1, 2'd3, 1'b1, 4'd0, 16'h0401, 2'b01, 2'd2, 32'd0});
        refill();

        d0 = drops;
        send_req(16'h0040, 3);
        @(negedge clk);
        chk("drop_pulse", {drop_err, req_ready, flit_valid}, {1'b1, 1'b1, 1'b0});
        @(negedge clk);
        chk("drop_one_cycle", {drop_err, req_ready}, {1'b0, 1'b1});
        repeat (3) @(negedge clk);
        chk("drop_count", 64'(drops - d0), 1);

        push_pkt(16'h00FF, 1, 32'h55);
        send_req(16'h00FF, 1);
        @(negedge clk);
        chk("sat_head", {flit_um_type, flit_mult_dst, flit_src_dst}, {1'b1, 16'h00BF, 2'd3});
        refill();
        push_pkt(16'h8040, 1, 32'h77);
        send_req(16'h8040, 1);
        refill();

        s0 = sent;
        push_pkt(16'h0003, 7, 32'h100);
        send_req(16'h0003, 7);
        repeat (10) @(negedge clk);
        chk("stall_after_4", 64'(sent - s0), 4);
        @(posedge clk);
        #1 credit_in = 1;
        @(posedge clk);
        #1 credit_in = 0;
        repeat (5) @(negedge clk);
        chk("one_credit_one_flit", 64'(sent - s0), 5);
        @(posedge clk);
        #1 credit_in = 1;
        repeat (2) @(posedge clk);
        #1 credit_in = 0;
        repeat (5) @(negedge clk);
        chk("coincident_credit", 64'(sent - s0), 7);

        @(posedge clk);
        #1 rst_n = 0;
        expq.delete();
        pq.delete();
        @(negedge clk);
        chk("mid_rst_outputs", {flit_valid, req_ready, dat_ready}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {flit_valid, req_ready}, {1'b0, 1'b1});
        s0 = sent;
        push_pkt(16'h0100, 7, 32'h200);
        send_req(16'h0100, 7);
        repeat (12) @(negedge clk);
        chk("post_rst_credit", 64'(sent - s0), 4);
        refill();
        chk("all_flits_drained", 64'(expq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
